// File: rtl/week_5_logic_unit_pipe.sv
`timescale 1ns/1ps
// week_5_logic_unit_pipe: WIDTH-bit AND/OR/XOR/NAND unit behind a STAGES-deep valid/ready
// pipeline with full backpressure. Define WEEK5_LOGIC_BEAT_COUNT_EN to enable the output beat counter.
module week_5_logic_unit_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      beat_count
);

  function automatic logic [WIDTH-1:0] logic_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z,
                                                input logic [1:0]       sel);
    case (sel)
      2'b00:   return x & z;
      2'b01:   return x | z;
      2'b10:   return x ^ z;
      default: return ~(x & z);
    endcase
  endfunction

  // Input side: result and zero flag evaluated combinationally from the operands
  logic [WIDTH-1:0] res_p0;
  logic             zero_p0;

  assign res_p0  = logic_op(a, b, op);
  assign zero_p0 = ~|res_p0;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] zero_q, zero_d;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [STAGES-1:0] rdy;
  logic [STAGES-1:0] src_vld, src_zero;
  logic [WIDTH-1:0]  src_data [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == 0) begin : g_head
      assign src_vld[g]  = in_valid;
      assign src_zero[g] = zero_p0;
      assign src_data[g] = res_p0;
    end else begin : g_body
      assign src_vld[g]  = vld_q[g-1];
      assign src_zero[g] = zero_q[g-1];
      assign src_data[g] = data_q[g-1];
    end
  end

  // A stage can take new data when empty or when its own content moves on this cycle
  always_comb begin : next_state
    logic acc;
    rdy = '0;
    acc = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc    = !vld_q[i] || acc;
      rdy[i] = acc;
    end
    vld_d  = vld_q;
    zero_d = zero_q;
    data_d = data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (rdy[i]) begin
        vld_d[i] = src_vld[i];
        if (src_vld[i]) begin
          data_d[i] = src_data[i];
          zero_d[i] = src_zero[i];
        end
      end
    end
  end

  // Stage registers; empty stages keep their last data so y holds while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      zero_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else begin
      vld_q  <= vld_d;
      zero_q <= zero_d;
      data_q <= data_d;
    end
  end

  // Output side: driven straight from the last stage
  assign in_ready  = rdy[0];
  assign y         = data_q[STAGES-1];
  assign y_zero    = zero_q[STAGES-1];
  assign out_valid = vld_q[STAGES-1];

`ifdef WEEK5_LOGIC_BEAT_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = cnt_q + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_count = cnt_q;
`else
  assign beat_count = 16'h0000;
`endif

endmodule

// File: tb/tb_week_5_logic_unit_pipe.sv
`timescale 1ns/1ps
// Bench for week_5_logic_unit_pipe: three instances (8/2, 1/1, 32/4) against a
// transaction-level queue model of the logic unit.
module tb_week_5_logic_unit_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] a_i  [3];
  logic [31:0] b_i  [3];
  logic [1:0]  op_i [3];
  logic        inv  [3];
  logic        ordy [3];
  logic        irdy [3];
  logic        ovld [3];
  logic        yz   [3];
  logic [15:0] bc   [3];
  logic [7:0]  y0;
  logic [0:0]  y1;
  logic [31:0] y2;

  week_5_logic_unit_pipe #(.WIDTH(8), .STAGES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .a(a_i[0][7:0]), .b(b_i[0][7:0]), .op(op_i[0]),
    .in_valid(inv[0]), .in_ready(irdy[0]), .y(y0), .y_zero(yz[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .beat_count(bc[0]));

  week_5_logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u1 (
    .clk(clk), .rst_n(rst_n), .a(a_i[1][0:0]), .b(b_i[1][0:0]), .op(op_i[1]),
    .in_valid(inv[1]), .in_ready(irdy[1]), .y(y1), .y_zero(yz[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .beat_count(bc[1]));

  week_5_logic_unit_pipe #(.WIDTH(32), .STAGES(4)) u2 (
    .clk(clk), .rst_n(rst_n), .a(a_i[2]), .b(b_i[2]), .op(op_i[2]),
    .in_valid(inv[2]), .in_ready(irdy[2]), .y(y2), .y_zero(yz[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .beat_count(bc[2]));

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          ocnt [3];
  bit          lat_chk;
  logic [31:0] exp_q [$];
  int          stamp_q [$];

  function automatic int wid(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 1 : 32);
  endfunction

  function automatic int stg(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 4);
  endfunction

  function automatic logic [31:0] yv(input int k);
    case (k)
      0:       return {24'h0, y0};
      1:       return {31'h0, y1};
      default: return y2;
    endcase
  endfunction

  function automatic logic [31:0] ref_model(input logic [31:0] x, input logic [31:0] z,
                                            input logic [1:0] o, input int k);
    logic [31:0] r, m;
    m = (wid(k) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(k)) - 32'd1);
    case (o)
      2'd0:    r = x & z;
      2'd1:    r = x | z;
      2'd2:    r = x ^ z;
      default: r = ~(x & z);
    endcase
    return r & m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("miscompare in %s", tag);
    end
  endtask

  // One clock cycle on instance k: model the transfers decided by the current inputs, then clock.
  task automatic step(input int k);
    bit          ix, ox;
    logic [31:0] e;
    int          st;
    #1;
    ix = inv[k] && irdy[k];
    ox = ovld[k] && ordy[k];
    if (ox) begin
      if (exp_q.size() == 0) begin
        chk("no_stale_beat", {31'h0, ovld[k]}, 32'h0);
      end else begin
        e  = exp_q.pop_front();
        st = stamp_q.pop_front();
        chk("y", yv(k), e);
        chk("y_zero", {31'h0, yz[k]}, {31'h0, (e == 32'h0)});
        if (lat_chk) chk("latency", cyc - st, stg(k));
      end
      ocnt[k]++;
    end
    if (ix) begin
      exp_q.push_back(ref_model(a_i[k], b_i[k], op_i[k], k));
      stamp_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input int k, input logic [31:0] av, input logic [31:0] bv,
                       input logic [1:0] ov, input logic v);
    a_i[k] = av; b_i[k] = bv; op_i[k] = ov; inv[k] = v;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=%0d expected_below=%0d", cyc, 90000);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] yh;
    int          n, guard;
    for (int k = 0; k < 3; k++) begin
      drive(k, 32'h0, 32'h0, 2'd0, 1'b0);
      ordy[k] = 1'b0;
      ocnt[k] = 0;
    end
    lat_chk = 1'b0;
    rst_n   = 1'b0;
    #12;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out_valid", {31'h0, ovld[k]}, 32'h0);
      chk("rst_y", yv(k), 32'h0);
      chk("rst_y_zero", {31'h0, yz[k]}, 32'h0);
      chk("rst_in_ready", {31'h0, irdy[k]}, 32'h1);
      chk("rst_beat_count", {16'h0, bc[k]}, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Truth table, unstalled: exact latency and order
    lat_chk = 1'b1;
    ordy[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'hF0, 32'h3C, 2'(i), 1'b1);
      step(0);
    end
    drive(0, 32'hAA, 32'h55, 2'd0, 1'b1);
    step(0);
    drive(0, 32'hAA, 32'h55, 2'd2, 1'b1);
    step(0);
    inv[0] = 1'b0;
    repeat (4) step(0);
    chk("tt_drained", exp_q.size(), 32'd0);

    // Backpressure: only STAGES beats fit, output holds, release reopens in_ready at once
    lat_chk = 1'b0;
    ordy[0] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 32'(i * 17 + 3), 32'hFF, 2'd1, 1'b1);
      step(0);
    end
    chk("bp_accepted", exp_q.size(), 32'd2);
    #1;
    chk("bp_in_ready_low", {31'h0, irdy[0]}, 32'h0);
    yh = yv(0);
    step(0);
    chk("bp_y_stable", yv(0), yh);
    chk("bp_out_valid_held", {31'h0, ovld[0]}, 32'h1);
    inv[0]  = 1'b0;
    ordy[0] = 1'b1;
    #1;
    chk("bp_in_ready_release", {31'h0, irdy[0]}, 32'h1);
    repeat (4) step(0);
    chk("bp_drained", exp_q.size(), 32'd0);

    // Reset mid-stream with two beats in flight
    ordy[0] = 1'b0;
    drive(0, 32'h81, 32'h7E, 2'd1, 1'b1);
    step(0);
    drive(0, 32'h0F, 32'hF0, 2'd2, 1'b1);
    step(0);
    inv[0] = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("mid_rst_out_valid", {31'h0, ovld[0]}, 32'h0);
    chk("mid_rst_y", yv(0), 32'h0);
    #2;
    rst_n = 1'b1;
    exp_q.delete();
    stamp_q.delete();
    for (int k = 0; k < 3; k++) ocnt[k] = 0;
    ordy[0] = 1'b1;
    chk("mid_rst_in_ready", {31'h0, irdy[0]}, 32'h1);
    repeat (5) step(0);

    // Random traffic per instance, then unstalled latency check
    for (int k = 0; k < 3; k++) begin
      lat_chk = 1'b0;
      repeat (300) begin
        drive(k, $urandom, $urandom, 2'($urandom_range(3)), 1'($urandom_range(1)));
        ordy[k] = 1'($urandom_range(1));
        step(k);
      end
      inv[k]  = 1'b0;
      ordy[k] = 1'b1;
      repeat (stg(k) + 2) step(k);
      chk("rand_drained", exp_q.size(), 32'd0);
      lat_chk = 1'b1;
      repeat (40) begin
        drive(k, $urandom, $urandom, 2'($urandom_range(3)), 1'($urandom_range(1)));
        step(k);
      end
      inv[k] = 1'b0;
      repeat (stg(k) + 2) step(k);
      chk("unstalled_drained", exp_q.size(), 32'd0);
      ordy[k] = 1'b0;
    end

`ifdef WEEK5_LOGIC_BEAT_COUNT_EN
    for (int k = 0; k < 3; k++) chk("beat_count_model", {16'h0, bc[k]}, 32'(ocnt[k] % 65536));
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive(0, 32'h5A, 32'hA5, 2'd2, 1'b1);
    ordy[0] = 1'b1;
    n = 0;
    guard = 0;
    while (n < 70000 && guard < 70100) begin
      #1;
      if (ovld[0] && ordy[0]) n++;
      @(posedge clk);
      #1;
      guard++;
      if (n == 70000) begin
        ordy[0] = 1'b0;
        inv[0]  = 1'b0;
      end
    end
    chk("long_run_transfers", n, 32'd70000);
    chk("beat_count_wrap", {16'h0, bc[0]}, 32'(70000 % 65536));
`else
    for (int k = 0; k < 3; k++) chk("beat_count_tied", {16'h0, bc[k]}, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
